// File: rtl/mul_seq_32_if.sv
// Start/done handshake and operand/product bus between a multiply requester
// (master) and the sequential multiplier (slave).
interface mul_seq_32_if;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [63:0] prod;

    modport master (output start, op_a, op_b, input ready, busy, done, prod);
    modport slave  (input start, op_a, op_b, output ready, busy, done, prod);
endinterface

// File: rtl/mul_seq_32.sv
// Sequential 32x32 unsigned shift-add multiplier reusing one CLA_32 adder.
// Optional MUL_ZERO_SKIP_EN: a zero operand finishes straight IDLE->DONE.
module mul_seq_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    mul_seq_32_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   sum;
    logic               co;
    logic               zero_op;

    CLA_32 u_cla (
        .A   (hi),
        .B   (mcand),
        .Cin (1'b0),
        .S   (sum),
        .Co  (co)
    );

`ifdef MUL_ZERO_SKIP_EN
    assign zero_op = (bus.op_a == '0) || (bus.op_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt; otherwise a latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.start) state_nxt = zero_op ? DONE : RUN;
            RUN:  if (cnt == CNT_W'(WIDTH - 1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (state == IDLE);
        bus.busy  = (state == RUN);
        bus.done  = (state == DONE);
        bus.prod  = {hi, lo};
    end

    // NOTE: registered state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: if (bus.start) begin
                    mcand <= bus.op_a;
                    hi    <= '0;
                    lo    <= zero_op ? '0 : bus.op_b;
                    cnt   <= '0;
                end
                RUN: begin
                    // Add-and-shift: the adder carry becomes the new MSB of hi.
                    if (lo[0]) {hi, lo} <= {co, sum, lo[WIDTH-1:1]};
                    else       {hi, lo} <= {1'b0, hi, lo[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// Two-level carry-lookahead adder: 4-bit group generate/propagate feed a
// lookahead carry chain across the eight groups.
module CLA_32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] S,
    output logic        Co
);
    logic [31:0] g;
    logic [31:0] p;
    logic [7:0]  gg;
    logic [7:0]  gp;
    logic [8:0]  bc;
    logic [31:0] c;

    assign g = A & B;
    assign p = A ^ B;

    always_comb begin
        gg = '0;
        gp = '0;
        bc = '0;
        c  = '0;
        for (int k = 0; k < 8; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        bc[0] = Cin;
        for (int k = 0; k < 8; k++) begin
            bc[k+1] = gg[k] | (gp[k] & bc[k]);
        end
        for (int k = 0; k < 8; k++) begin
            c[4*k] = bc[k];
            for (int j = 1; j < 4; j++) begin
                c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
            end
        end
        S  = p ^ c;
        Co = bc[8];
    end
endmodule

// File: tb/tb_mul_seq_32.sv
// Self-checking bench for mul_seq_32: cycle-level behavioural model plus
// directed literal cases, reset abort, randomized and back-to-back traffic.
module tb_mul_seq_32;
`ifdef MUL_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
    localparam int ZLAT      = 1;
`else
    localparam bit ZERO_SKIP = 1'b0;
    localparam int ZLAT      = 33;
`endif

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    mul_seq_32_if bus ();

    mul_seq_32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: cycles left until the product appears, plus the held product.
    bit          m_on   = 1'b0;
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [63:0] m_prod = '0;
    logic [63:0] m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_on   <= 1'b1;
            m_left <= 0;
            m_done <= 1'b0;
            m_prod <= '0;
        end else if (m_on) begin
            if (m_done) begin
                m_done <= 1'b0;
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_prod <= m_pend;
                end
            end else if (bus.start) begin
                m_pend <= 64'(bus.op_a) * 64'(bus.op_b);
                if (ZERO_SKIP && (bus.op_a == 0 || bus.op_b == 0)) begin
                    m_done <= 1'b1;
                    m_prod <= '0;
                end else begin
                    m_left <= 32;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("ready", 64'(bus.ready), 64'(m_left == 0 && !m_done));
            check("busy",  64'(bus.busy),  64'(m_left != 0));
            check("done",  64'(bus.done),  64'(m_done));
            if (m_left == 0) check("prod", bus.prod, m_prod);
        end
    end

    task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input int exp_lat, input logic [63:0] exp_prod, input int poke_at);
        int w;
        int lat;
        w = 0;
        while (!bus.ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check({name, "_ready_before"}, 64'(bus.ready), 64'd1);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
        lat = 1;
        while (!bus.done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat == poke_at) begin
                bus.start = 1'b1;
                bus.op_a  = 32'd1;
                bus.op_b  = 32'd1;
            end else if (lat == poke_at + 1) begin
                bus.start = 1'b0;
            end
        end
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_prod"}, bus.prod, exp_prod);
        @(posedge clk); #1;
        check({name, "_ready_after"}, 64'(bus.ready), 64'd1);
    endtask

    initial begin
        int done_cnt;
        int acc[$];
        logic [31:0] a;
        logic [31:0] b;

        clk = 1'b0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_ready", 64'(bus.ready), 64'd1);
        check("rst_busy",  64'(bus.busy),  64'd0);
        check("rst_done",  64'(bus.done),  64'd0);
        check("rst_prod",  bus.prod,       64'h0);

        run_mul("basic", 32'd3, 32'd5, 33, 64'h0000_0000_0000_000F, 0);
        run_mul("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 64'hFFFF_FFFE_0000_0001, 0);
        run_mul("busy_start", 32'h1234_5678, 32'h9ABC_DEF0, 33, 64'h0B00_EA4E_242D_2080, 6);

        // Abort an operation at RUN step 10.
        bus.start = 1'b1;
        bus.op_a  = 32'hCAFE_F00D;
        bus.op_b  = 32'h0BAD_BEEF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_ready", 64'(bus.ready), 64'd1);
        check("abort_busy",  64'(bus.busy),  64'd0);
        check("abort_prod",  bus.prod,       64'h0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) done_cnt++;
            @(posedge clk); #1;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        run_mul("after_rst", 32'd7, 32'd9, 33, 64'd63, 0);

        run_mul("zero_a", 32'd0, 32'hDEAD_BEEF, ZLAT, 64'h0, 0);
        run_mul("zero_b", 32'h0000_1234, 32'd0, ZLAT, 64'h0, 0);

        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 7 == 3) a = '0;
            run_mul("rand", a, b, (a == 0 || b == 0) ? ZLAT : 33, 64'(a) * 64'(b), 0);
        end

        // Back-to-back: start held high, operands change every cycle.
        bus.start = 1'b1;
        for (int cyc = 0; cyc < 4 * 34 + 5; cyc++) begin
            bus.op_a = $urandom | 32'd1;
            bus.op_b = $urandom | 32'd1;
            if (bus.ready) acc.push_back(cyc);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        check("b2b_accepts", 64'(acc.size()), 64'd5);
        for (int i = 1; i < acc.size(); i++) begin
            check("b2b_spacing", 64'(acc[i] - acc[i-1]), 64'd34);
        end
        for (int i = 0; i < 40 && !bus.ready; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        check("b2b_drain_ready", 64'(bus.ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_seq_32.md
# mul_seq_32

Sequential 32x32 unsigned multiplier controller that time-shares one `CLA_32` carry-lookahead adder instance across 32 shift-add iterations to produce a 64-bit product. It sits beside the integer ALU in the RISC-V execute stage and serves multi-cycle multiply operations (MUL, MULHU) through a start/done handshake. It trades latency for area by reusing the existing adder instead of an array multiplier.

## Interface
- `WIDTH`, 32: operand width; only 32 is supported, because the block instantiates `CLA_32` directly.
- `CNT_W`, 6: iteration counter width; must hold the value 32.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a multiply; sampled only when `ready`=1.
- `op_a`  in  32  multiplicand; captured on an accepted `start`.
- `op_b`  in  32  multiplier; captured on an accepted `start`.
- `ready`  out  1  high in IDLE only.
- `busy`  out  1  high in RUN only.
- `done`  out  1  one-cycle pulse in DONE; `prod` is valid.
- `prod`  out  64  product {hi, lo}; holds its value until the next accepted `start` or `rst`.

## Operation
- Registers:
  - `mcand[31:0]`
  - `hi[31:0]`: accumulator
  - `lo[31:0]`: multiplier / product-low
  - `cnt[CNT_W-1:0]`
  - `state`: one of IDLE, RUN, DONE
- Adder hookup:
  - `CLA_32` A=`hi`, B=`mcand`, Cin=0, giving sum S and carry Co.
  - The adder is combinational, and only `hi` and `mcand` feed it.
- IDLE:
  - Drives `ready`=1.
  - On `start`=1: `mcand`<=`op_a`, `hi`<=0, `lo`<=`op_b`, `cnt`<=0, state<=RUN.
  - On `start`=0: stay in IDLE.
- RUN, one step per cycle:
  - If `lo[0]`=1: {hi, lo} <= {Co, S, lo[31:1]}.
  - If `lo[0]`=0: {hi, lo} <= {1'b0, hi, lo[31:1]}.
  - `cnt`<=`cnt`+1.
  - When the step executed has `cnt`==31, state<=DONE.
- DONE:
  - Drives `done`=1 for exactly one cycle.
  - `prod`={hi, lo}.
  - Unconditionally returns to IDLE on the next edge.
- Arithmetic: unsigned only. The 33-bit partial sum {Co, S} never overflows the 64-bit window. Result = op_a*op_b mod 2^64, which is exact.
- `start` while RUN or DONE: ignored; operands are not re-captured.
- `op_a`/`op_b` may change after acceptance without effect.
- `prod` is driven from the hi/lo registers; it stays stable in IDLE after DONE and changes during RUN.
- `rst`=1 at any edge, including mid-RUN:
  - state<=IDLE; `hi`, `lo`, `mcand`, `cnt` <= 0.
  - The in-flight operation is discarded with no `done`.
  - `rst` has priority over `start`.

## Timing
- Reset values:
  - `ready`=1, `busy`=0, `done`=0, `prod`=64'h0.
  - state IDLE, `cnt`=0.
- Start accepted at edge E0 ⇒ `busy`=1 from E0 through E32.
- 32 RUN steps occupy edges E1..E32.
- `done`=1 in the cycle after E32.
- `ready`=1 again after E33.
- Latency from the accepting edge to the `done` cycle is 33 clocks. Issue interval is 34 clocks (the earliest next accept is at E33 + 1 cycle in IDLE, i.e. `start` held high re-accepts at E34).
- `ready`, `busy` and `done` are decoded purely from state; they are mutually exclusive and exactly one is high.
- Critical path: `hi`/`mcand` → `CLA_32` → `hi`; there is no other logic in series beyond a 2:1 mux.

## Configuration
- `MUL_ZERO_SKIP_EN` defined:
  - On an accepted `start` with `op_a`==0 or `op_b`==0, load `hi`<=0, `lo`<=0 and go straight IDLE→DONE.
  - `done` appears in the cycle after the accepting edge, a latency of 1.
  - Nonzero operands behave as above.
- Not defined: zero operands take the full 33-clock path, and `prod`=0.

## Test plan
- Basic product:
  - Stimulus: after `rst`, `start`, op_a=3, op_b=5.
  - Required response: `done` exactly 33 clocks after the accept; prod=64'h0000_0000_0000_000F; `ready` returns the following cycle.
- Max operands:
  - Stimulus: op_a=op_b=32'hFFFF_FFFF.
  - Required response: prod=64'hFFFF_FFFE_0000_0001, which exercises Co into `hi`.
- Start while busy:
  - Stimulus: op_a=32'h1234_5678, op_b=32'h9ABC_DEF0; pulse `start` with op_a=1, op_b=1 during RUN.
  - Required response: the pulse is ignored; prod=64'h0B00_EA4E_242D_2080.
- Reset mid-operation:
  - Stimulus: assert `rst` at RUN step 10.
  - Required response: next cycle `ready`=1, `busy`=0, prod=0; no `done` ever pulses.
  - Then: a fresh 7*9 yields 63 after 33 clocks.
- Zero operand:
  - Stimulus: op_a=0, op_b=32'hDEAD_BEEF.
  - Required response: prod=0; `done` at latency 1 with `MUL_ZERO_SKIP_EN` defined, latency 33 without.
- Back-to-back:
  - Stimulus: `start` held high continuously with changing operands.
  - Required response: accepts spaced 34 clocks apart; every product matches the reference model.
